// File: rtl/frame_bank_pkg.sv
// Shared types and constants for the triple-buffered frame bank scheduler.
package frame_bank_pkg;

  localparam int NUM_BANKS = 3;

  typedef logic [1:0] bank_t;

  localparam bank_t WR_BANK_RST  = 2'd0;
  localparam bank_t RD_BANK_RST  = 2'd1;
  localparam bank_t RDY_BANK_RST = 2'd2;

  typedef enum logic {
    WR_IDLE    = 1'b0,
    WR_WRITING = 1'b1
  } wr_state_e;

  function automatic logic [2:0] bank_onehot(input bank_t b);
    return 3'b001 << b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with increment enable that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer scheduler: capture writes one bank, display reads another,
// the third holds the most recent completed frame waiting to be shown.
//
// state      | meaning
// WR_IDLE    | capture between frames, writes gated off
// WR_WRITING | capture filling wr_bank
module frame_bank_scheduler
  import frame_bank_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int NUM_BANKS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_frame_start,
  input  logic             wr_frame_done,
  input  logic             wr_en,
  input  logic             rd_frame_start,
  input  logic             freeze,
  output logic [1:0]       wr_bank,
  output logic [1:0]       rd_bank,
  output logic [2:0]       wr_en_bank,
  output logic             ready_valid,
  output logic             swap_pulse,
  output logic [CNT_W-1:0] frames_shown,
  output logic [CNT_W-1:0] frames_dropped
);

  if (NUM_BANKS != frame_bank_pkg::NUM_BANKS) begin : g_bad_num_banks
    $error("frame_bank_scheduler supports exactly three banks");
  end

  wr_state_e state_q, state_d;
  bank_t     wr_bank_q, wr_bank_d;
  bank_t     rd_bank_q, rd_bank_d;
  bank_t     rdy_bank_q, rdy_bank_d;
  logic      ready_valid_q, ready_valid_d;
  logic      swap_pulse_q, swap_pulse_d;
  logic      wr_accept;
  logic      rd_accept;
  logic      inc_shown;
  logic      inc_dropped;

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    rdy_bank_d    = rdy_bank_q;
    ready_valid_d = ready_valid_q;
    swap_pulse_d  = 1'b0;
    inc_shown     = 1'b0;
    inc_dropped   = 1'b0;

    wr_accept = (state_q == WR_WRITING) && wr_frame_done && !freeze;
    // A frame completing this same cycle is displayable immediately.
    rd_accept = rd_frame_start && (ready_valid_q || wr_accept);

    case (state_q)
      WR_IDLE:    if (wr_frame_start) state_d = WR_WRITING;
      WR_WRITING: if (wr_frame_done)  state_d = WR_IDLE;
      default:    state_d = WR_IDLE;
    endcase

    if (wr_accept) begin
      wr_bank_d     = rdy_bank_q;
      rdy_bank_d    = wr_bank_q;
      ready_valid_d = 1'b1;
      inc_dropped   = ready_valid_q;
    end

    // Read swap is layered on top of the write swap result.
    if (rd_accept) begin
      rd_bank_d     = rdy_bank_d;
      rdy_bank_d    = rd_bank_q;
      ready_valid_d = 1'b0;
      swap_pulse_d  = 1'b1;
      inc_shown     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WR_IDLE;
      wr_bank_q     <= WR_BANK_RST;
      rd_bank_q     <= RD_BANK_RST;
      rdy_bank_q    <= RDY_BANK_RST;
      ready_valid_q <= 1'b0;
      swap_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      rdy_bank_q    <= rdy_bank_d;
      ready_valid_q <= ready_valid_d;
      swap_pulse_q  <= swap_pulse_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_shown (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (inc_shown),
    .count  (frames_shown)
  );

  sat_counter #(.CNT_W(CNT_W)) u_dropped (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (inc_dropped),
    .count  (frames_dropped)
  );

  assign wr_en_bank  = (state_q == WR_WRITING && wr_en) ? bank_onehot(wr_bank_q) : 3'b000;
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign ready_valid = ready_valid_q;
  assign swap_pulse  = swap_pulse_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed scenarios plus random traffic against a role-based bank model.
module tb_frame_bank_scheduler;

  localparam int CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_frame_start = 1'b0;
  logic        wr_frame_done = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_frame_start = 1'b0;
  logic        freeze = 1'b0;
  logic [1:0]  wr_bank;
  logic [1:0]  rd_bank;
  logic [2:0]  wr_en_bank;
  logic        ready_valid;
  logic        swap_pulse;
  logic [15:0] frames_shown;
  logic [15:0] frames_dropped;

  int total = 0;
  int bad = 0;

  // Reference: which bank plays which role, plus event bookkeeping.
  int m_writing, m_wr, m_rd, m_rdy, m_valid, m_swap, m_shown, m_dropped;

  frame_bank_scheduler #(.CNT_W(16), .NUM_BANKS(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_frame_start (wr_frame_start),
    .wr_frame_done  (wr_frame_done),
    .wr_en          (wr_en),
    .rd_frame_start (rd_frame_start),
    .freeze         (freeze),
    .wr_bank        (wr_bank),
    .rd_bank        (rd_bank),
    .wr_en_bank     (wr_en_bank),
    .ready_valid    (ready_valid),
    .swap_pulse     (swap_pulse),
    .frames_shown   (frames_shown),
    .frames_dropped (frames_dropped)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_writing = 0; m_wr = 0; m_rd = 1; m_rdy = 2;
    m_valid = 0; m_swap = 0; m_shown = 0; m_dropped = 0;
  endtask

  task automatic model_step();
    int  t;
    bit  done_ok, show_ok;
    done_ok = (m_writing != 0) && wr_frame_done && !freeze;
    show_ok = rd_frame_start && (m_valid != 0 || done_ok);
    if (done_ok) begin
      t = m_wr; m_wr = m_rdy; m_rdy = t;
      if (m_valid != 0 && m_dropped < CNT_MAX) m_dropped++;
      m_valid = 1;
    end
    if (show_ok) begin
      t = m_rd; m_rd = m_rdy; m_rdy = t;
      m_valid = 0;
      if (m_shown < CNT_MAX) m_shown++;
    end
    m_swap = show_ok ? 1 : 0;
    if (m_writing == 0 && wr_frame_start) m_writing = 1;
    else if (m_writing != 0 && wr_frame_done) m_writing = 0;
  endtask

  task automatic check_all();
    int exp_en;
    exp_en = (m_writing != 0 && wr_en) ? (1 << m_wr) : 0;
    chk("wr_bank", 32'(wr_bank), m_wr);
    chk("rd_bank", 32'(rd_bank), m_rd);
    chk("ready_valid", 32'(ready_valid), m_valid);
    chk("swap_pulse", 32'(swap_pulse), m_swap);
    chk("frames_shown", 32'(frames_shown), m_shown);
    chk("frames_dropped", 32'(frames_dropped), m_dropped);
    chk("wr_en_bank", 32'(wr_en_bank), exp_en);
    chk("perm", 32'((wr_bank != rd_bank) && (wr_bank < 2'd3) && (rd_bank < 2'd3)), 1);
  endtask

  // Called at a negedge: apply inputs, let one edge pass, compare, return at negedge.
  task automatic step(input bit s, input bit d, input bit e, input bit r, input bit f);
    wr_frame_start = s; wr_frame_done = d; wr_en = e; rd_frame_start = r; freeze = f;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    wr_frame_start = 0; wr_frame_done = 0; wr_en = 0; rd_frame_start = 0; freeze = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Basic capture then display.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("s1_wr", 32'(wr_bank), 2);
    chk("s1_rd", 32'(rd_bank), 0);
    chk("s1_shown", 32'(frames_shown), 1);
    chk("s1_pulse", 32'(swap_pulse), 1);
    step(0, 0, 0, 0, 0);
    chk("s1_pulse_end", 32'(swap_pulse), 0);

    // Two frames, no display: one dropped.
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("s2_dropped", 32'(frames_dropped), 1);
    chk("s2_valid", 32'(ready_valid), 1);
    chk("s2_wr", 32'(wr_bank), 0);

    // Completion and display in the same cycle.
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    chk("s3_wr", 32'(wr_bank), 2);
    chk("s3_rd", 32'(rd_bank), 0);
    chk("s3_valid", 32'(ready_valid), 0);
    chk("s3_dropped", 32'(frames_dropped), 0);

    // Frozen: completed frames discarded.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 1);
      step(0, 1, 0, 0, 1);
    end
    step(0, 0, 0, 1, 1);
    chk("s4_rd", 32'(rd_bank), 1);
    chk("s4_pulse", 32'(swap_pulse), 0);
    chk("s4_cnt", 32'(frames_shown) + 32'(frames_dropped), 0);

    // Restart mid-frame, then asynchronous reset mid-frame.
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("s5_en0", 32'(wr_en_bank), 1);
    step(1, 0, 1, 0, 0);
    chk("s5_en_abort", 32'(wr_en_bank), 1);
    step(0, 0, 0, 0, 0);
    chk("s5_en_off", 32'(wr_en_bank), 0);
    wr_en = 1'b1;
    #1;
    chk("s5_en_comb", 32'(wr_en_bank), 1);
    do_reset();
    chk("s5_rst_en", 32'(wr_en_bank), 0);
    chk("s5_rst_rd", 32'(rd_bank), 1);

    // Saturation of the shown counter.
    do_reset();
    force dut.u_shown.cnt_q = 16'hFFFE;
    #1;
    release dut.u_shown.cnt_q;
    m_shown = 32'hFFFE;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0);
    end
    chk("s6_sat", 32'(frames_shown), 32'hFFFF);

    // Random traffic.
    do_reset();
    begin
      bit fz;
      fz = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 19) == 0) fz = ~fz;
        step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) == 0, fz);
        if ($urandom_range(0, 499) == 0) do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
